// File: rtl/boot_loader.sv
// boot_loader: power-up program loader.
// Holds the core in reset. Receives a little-endian 32-bit word count followed by that many
// little-endian words over UART rx. Writes each word to instruction RAM starting at
// BASE_WORD. Sends ACK_BYTE on UART tx, then releases the core.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   rx_data/rx_ready    received byte and its valid flag
//   rx_take             combinational consume strobe (byte taken when rx_ready & rx_take)
//   tx_data/tx_start    ACK byte and one-cycle transmit request
//   tx_busy             transmitter busy; tx_start waits for it to drop
//   imem_we/addr/din    instruction RAM write port (word addressed)
//   core_rstn           active-low core reset, high only once loading is complete
//   done                load complete (same as core_rstn)
//   err                 sticky: image exceeded memory capacity
module boot_loader #(
  parameter int unsigned MEM       = 10,
  parameter int unsigned BASE_WORD = 32,
  parameter logic [7:0]  ACK_BYTE  = 8'hAA
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     rx_data,
  input  logic           rx_ready,
  output logic           rx_take,
  output logic [7:0]     tx_data,
  output logic           tx_start,
  input  logic           tx_busy,
  output logic           imem_we,
  output logic [MEM-3:0] imem_addr,
  output logic [31:0]    imem_din,
  output logic           core_rstn,
  output logic           done,
  output logic           err
);

  localparam int unsigned AW = MEM - 2;

  typedef enum logic [2:0] {
    StLen,
    StData,
    StWrite,
    StAckW,
    StAckS,
    StRun
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] len_q, len_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic        err_q, err_d;

  // Full-width target address; the top bit catches overflow past the RAM.
  logic [32:0] addr_full;
  logic        in_range;

  assign addr_full = 33'(BASE_WORD) + {1'b0, cnt_q};
  assign in_range  = addr_full < (33'd1 << AW);

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    err_d      = err_q;
    rx_take    = 1'b0;
    imem_we    = 1'b0;
    imem_addr  = '0;
    imem_din   = '0;
    tx_start   = 1'b0;
    tx_data    = '0;
    core_rstn  = 1'b0;

    unique case (state_q)
      StLen: begin
        rx_take = !rst;
        if (rx_ready) begin
          len_d[8*byte_idx_q +: 8] = rx_data;
          byte_idx_d               = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            byte_idx_d = '0;
            cnt_d      = '0;
            // Decide on the count just assembled, not the stale register.
            state_d    = ({rx_data, len_q[23:0]} == 32'd0) ? StAckW : StData;
          end
        end
      end
      StData: begin
        rx_take = !rst;
        if (rx_ready) begin
          word_d[8*byte_idx_q +: 8] = rx_data;
          byte_idx_d                = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            byte_idx_d = '0;
            state_d    = StWrite;
          end
        end
      end
      StWrite: begin
        imem_din  = word_q;
        imem_addr = addr_full[AW-1:0];
        // Out-of-range words are dropped rather than wrapped into low memory.
        if (in_range) imem_we = 1'b1;
        else          err_d   = 1'b1;
        cnt_d   = cnt_q + 32'd1;
        state_d = (cnt_q + 32'd1 == len_q) ? StAckW : StData;
      end
      StAckW: begin
        if (!tx_busy) state_d = StAckS;
      end
      StAckS: begin
        tx_start = 1'b1;
        tx_data  = ACK_BYTE;
        state_d  = StRun;
      end
      StRun: begin
        core_rstn = 1'b1;
      end
      default: state_d = StLen;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StLen;
      byte_idx_q <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      word_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      err_q      <= err_d;
    end
  end

  assign done = core_rstn;
  assign err  = err_q;

endmodule

// File: tb/tb_boot_loader.sv
module tb_boot_loader;

  localparam int unsigned MEM   = 8;
  localparam int unsigned AW    = MEM - 2;
  localparam int unsigned BASE  = 32;
  localparam int unsigned WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          rx_take;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_din;
  logic          core_rstn;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  boot_loader #(
    .MEM      (MEM),
    .BASE_WORD(BASE),
    .ACK_BYTE (8'hAA)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .rx_take  (rx_take),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .imem_we  (imem_we),
    .imem_addr(imem_addr),
    .imem_din (imem_din),
    .core_rstn(core_rstn),
    .done     (done),
    .err      (err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   din;
  } wr_t;

  int          vectors     = 0;
  int          miscompares = 0;
  wr_t         exp_q[$];
  logic [31:0] img[$];
  int          ack_cnt     = 0;
  int          wr_cnt      = 0;

  // Scoreboard side: pops expected writes and watches ACK / release ordering.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (imem_we === 1'b1) begin
        wr_t e;
        wr_cnt++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write addr=%0d din=%h, required no write", imem_addr,
                   imem_din);
        end else begin
          e = exp_q.pop_front();
          if (imem_addr !== e.addr || imem_din !== e.din) begin
            miscompares++;
            $display("FAIL write addr/din got %0d/%h, required %0d/%h", imem_addr, imem_din,
                     e.addr, e.din);
          end
        end
        vectors++;
        if (rx_take !== 1'b0) begin
          miscompares++;
          $display("FAIL take_in_write rx_take=%b, required 0", rx_take);
        end
      end
      if (tx_start === 1'b1) begin
        ack_cnt++;
        vectors++;
        if (tx_data !== 8'hAA || tx_busy !== 1'b0) begin
          miscompares++;
          $display("FAIL ack tx_data=%h tx_busy=%b, required AA/0", tx_data, tx_busy);
        end
      end
      if (core_rstn === 1'b1 && ack_cnt == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL early_release core_rstn=1, required 0 before ACK");
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    rx_ready = 1'b0;
    @(negedge clk);
    ack_cnt = 0;
    wr_cnt  = 0;
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit taken = 1'b0;
    int guard = 0;
    @(negedge clk);
    rx_ready = 1'b1;
    rx_data  = b;
    while (!taken && guard < 50) begin
      #1;
      taken = rx_take;
      @(posedge clk);
      if (!taken) @(negedge clk);
      guard++;
    end
    if (!taken) begin
      vectors++;
      miscompares++;
      $display("FAIL byte_timeout byte=%h not taken, required taken", b);
    end
  endtask

  task automatic idle_gap(input int g);
    if (g > 0) begin
      @(negedge clk);
      rx_ready = 1'b0;
      repeat (g - 1) @(negedge clk);
    end
  endtask

  // Sends count n then img[0..n-1]; queues the writes that fit in RAM.
  task automatic load_image(input int n, input int maxgap);
    logic [31:0] v;
    for (int k = 0; k < n; k++)
      if (BASE + k < WORDS) exp_q.push_back('{addr: AW'(BASE + k), din: img[k]});
    v = 32'(n);
    for (int i = 0; i < 4; i++) begin
      if (maxgap > 0) idle_gap($urandom_range(0, maxgap));
      send_byte(v[8*i +: 8]);
    end
    for (int k = 0; k < n; k++) begin
      v = img[k];
      for (int i = 0; i < 4; i++) begin
        if (maxgap > 0) idle_gap($urandom_range(0, maxgap));
        send_byte(v[8*i +: 8]);
      end
    end
  endtask

  task automatic wait_done(input string name);
    int guard = 0;
    while (done !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    rx_ready = 1'b0;
    vectors++;
    if (done !== 1'b1 || core_rstn !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_done done=%b core_rstn=%b, required 1/1", name, done, core_rstn);
    end
    vectors++;
    if (ack_cnt != 1) begin
      miscompares++;
      $display("FAIL %s_ack_count got %0d, required 1", name, ack_cnt);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_missing_writes %0d pending, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst      = 1'b1;
    rx_ready = 1'b1;
    rx_data  = 8'h55;
    #1;
    vectors++;
    if (rx_take !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_take rx_take=%b, required 0", rx_take);
    end
    @(negedge clk);
    vectors++;
    if ({core_rstn, done, err, imem_we, tx_start, imem_addr, tx_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs rstn=%b done=%b err=%b we=%b txs=%b addr=%0d txd=%h, required 0",
               core_rstn, done, err, imem_we, tx_start, imem_addr, tx_data);
    end
    do_reset();
  endtask

  task automatic test_single_word();
    do_reset();
    img.delete();
    img.push_back(32'h00A00513);
    load_image(1, 0);
    wait_done("single");
    vectors++;
    if (wr_cnt != 1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL single_writes/err got %0d/%b, required 1/0", wr_cnt, err);
    end
  endtask

  task automatic test_zero_len_busy();
    do_reset();
    tx_busy = 1'b1;
    img.delete();
    load_image(0, 0);
    @(negedge clk);
    rx_ready = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (ack_cnt != 0 || core_rstn !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_hold ack=%0d core_rstn=%b, required 0/0", ack_cnt, core_rstn);
    end
    tx_busy = 1'b0;
    wait_done("zero_len");
    vectors++;
    if (wr_cnt != 0) begin
      miscompares++;
      $display("FAIL zero_len_writes got %0d, required 0", wr_cnt);
    end
  endtask

  task automatic test_back_to_back(input int maxgap, input string name);
    do_reset();
    img.delete();
    img.push_back(32'hDEADBEEF);
    img.push_back(32'h12345678);
    img.push_back(32'h0F0F00FF);
    load_image(3, maxgap);
    wait_done(name);
    vectors++;
    if (wr_cnt != 3 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_writes/err got %0d/%b, required 3/0", name, wr_cnt, err);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    img.delete();
    for (int k = 0; k < 33; k++) img.push_back(32'hC0DE0000 + 32'(k));
    load_image(33, 0);
    wait_done("overflow");
    vectors++;
    if (wr_cnt != 32 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_writes/err got %0d/%b, required 32/1", wr_cnt, err);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    img.delete();
    img.push_back(32'h11111111);
    img.push_back(32'h22222222);
    // Partial image: count + two data bytes, nothing expected to be written.
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h11);
    do_reset();
    vectors++;
    if (core_rstn !== 1'b0 || wr_cnt != 0) begin
      miscompares++;
      $display("FAIL midreset_state core_rstn=%b writes=%0d, required 0/0", core_rstn, wr_cnt);
    end
    img.delete();
    img.push_back(32'hCAFEF00D);
    load_image(1, 0);
    wait_done("midreset");
    vectors++;
    if (wr_cnt != 1) begin
      miscompares++;
      $display("FAIL midreset_writes got %0d, required 1", wr_cnt);
    end
  endtask

  initial begin
    rst      = 1'b1;
    rx_ready = 1'b0;
    rx_data  = '0;
    tx_busy  = 1'b0;
    test_reset();
    test_single_word();
    test_zero_len_busy();
    test_back_to_back(0, "b2b");
    test_overflow();
    test_mid_reset();
    test_back_to_back(10, "gaps");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
